// File: rtl/slave_internal_response_b_arbiter.sv
// Merges N_SRC internal write-response sources into one AXI B channel via a
// round-robin or fixed-priority arbiter feeding a response FIFO.
module slave_internal_response_b_arbiter #(
    parameter int N_SRC      = 2,
    parameter int ID_WIDTH   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ARB_MODE   = 0
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [N_SRC-1:0]              src_bvalid,
    output logic [N_SRC-1:0]              src_bready,
    input  logic [N_SRC*ID_WIDTH-1:0]     src_bid,
    input  logic [N_SRC*2-1:0]            src_bresp,
    output logic                          BVALID,
    input  logic                          BREADY,
    output logic [ID_WIDTH-1:0]           BID,
    output logic [1:0]                    BRESP,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(N_SRC);
    localparam int EW = ID_WIDTH + 2;

    typedef logic [EW-1:0] entry_t;

    entry_t         mem [FIFO_DEPTH];
    entry_t         head;
    entry_t         last_popped;
    entry_t         push_entry;
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [SW-1:0]  rr_ptr;
    logic [SW-1:0]  grant_idx;
    logic [N_SRC-1:0] eligible;
    logic           full;
    logic           push;
    logic           pop;

    assign full = (fifo_count == (PW+1)'(FIFO_DEPTH));

    // Full FIFO blocks all grants, even when a pop happens in the same cycle.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        eligible   = (full || ARESET) ? '0 : src_bvalid;
        src_bready = '0;
        grant_idx  = '0;
        push       = 1'b0;
        if (ARB_MODE == 1) begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (eligible[i]) begin
                    grant_idx = SW'(i);
                    push      = 1'b1;
                end
            end
        end else begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_SRC) idx = idx - N_SRC;
                if (!push && eligible[idx]) begin
                    grant_idx = SW'(idx);
                    push      = 1'b1;
                end
            end
        end
        if (push) src_bready[grant_idx] = 1'b1;
    end

    assign push_entry = {src_bid[grant_idx*ID_WIDTH +: ID_WIDTH], src_bresp[grant_idx*2 +: 2]};
    assign head       = mem[rd_ptr];
    assign BVALID     = (fifo_count != '0);
    assign pop        = BVALID && BREADY;
    // When empty, the outputs show the last popped entry rather than stale RAM.
    assign {BID, BRESP} = BVALID ? head : last_popped;

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            rr_ptr      <= '0;
            fifo_count  <= '0;
            last_popped <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= (grant_idx == SW'(N_SRC-1)) ? '0 : grant_idx + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                last_popped <= head;
            end
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

endmodule
